// File: rtl/data_tape_if.sv
// rtl/data_tape_if.sv - operation/response bundle between the data operation unit and the data tape
// Signals:
//   flag_op_ptr  pointer opcode (NOP / MOD / SET / RST)
//   code         instruction word carrying the sign, inst8 and inst12 immediates
//   data_wr      write strobe for the current cell (level, one write per sampled cycle)
//   data_in      value written verbatim into the current cell
//   data         registered value of the cell at ptr
//   ptr          registered cell pointer
//   busy         high while the tape is being cleared; operations are ignored
// Modports: master = data operation unit side, slave = tape side.
interface data_tape_if #(
   parameter int DATA_BITWIDTH = 8,
   parameter int CODE_BITWIDTH = 16,
   parameter int ADDR_BITWIDTH = 10
);
   logic [1:0]               flag_op_ptr;
   logic [CODE_BITWIDTH-1:0] code;
   logic                     data_wr;
   logic [DATA_BITWIDTH-1:0] data_in;
   logic [DATA_BITWIDTH-1:0] data;
   logic [ADDR_BITWIDTH-1:0] ptr;
   logic                     busy;

   modport master (
      output flag_op_ptr, code, data_wr, data_in,
      input  data, ptr, busy
   );

   modport slave (
      input  flag_op_ptr, code, data_wr, data_in,
      output data, ptr, busy
   );
endinterface

// File: rtl/data_tape.sv
// rtl/data_tape.sv - tape cell storage with pointer, write-through read forwarding and post-reset clear
// Ports:
//   i_clk   single clock, all logic on the rising edge
//   i_rst   synchronous active-high reset; restarts the clear sweep from address 0
//   bus     data_tape_if.slave: flag_op_ptr/code/data_wr/data_in in, data/ptr/busy out
module data_tape #(
   parameter int         DATA_BITWIDTH = 8,
   parameter int         CODE_BITWIDTH = 16,
   parameter int         ADDR_BITWIDTH = 10,
   parameter logic [1:0] PTR_NOP       = 2'h0,
   parameter logic [1:0] PTR_MOD       = 2'h1,
   parameter logic [1:0] PTR_SET       = 2'h2,
   parameter logic [1:0] PTR_RST       = 2'h3
) (
   input  logic       i_clk,
   input  logic       i_rst,
   data_tape_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_BITWIDTH;

   typedef enum logic {
      S_CLEAR = 1'b0,
      S_READY = 1'b1
   } state_t;

   state_t                   r_state;
   state_t                   w_state_next;
   logic [ADDR_BITWIDTH-1:0] r_clr_addr;
   logic [ADDR_BITWIDTH-1:0] r_ptr;
   logic [ADDR_BITWIDTH-1:0] w_ptr_next;
   logic [DATA_BITWIDTH-1:0] r_data;
   logic [DATA_BITWIDTH-1:0] r_mem [DEPTH];

   logic                     w_sign;
   logic [7:0]               w_inst8;
   logic [11:0]              w_inst12;
   logic [ADDR_BITWIDTH-1:0] w_inst8_ext;
   logic                     w_unused_code;

   logic                     w_busy;
   logic                     w_mem_we;
   logic [ADDR_BITWIDTH-1:0] w_mem_addr;
   logic [DATA_BITWIDTH-1:0] w_mem_wdata;
   logic                     w_fwd;

   // Immediate fields sit at the top of the code word; the low nibble is opcode space
   // owned by the data operation unit and is not used here.
   assign w_sign        = bus.code[CODE_BITWIDTH-1];
   assign w_inst12      = bus.code[CODE_BITWIDTH-1 -: 12];
   assign w_inst8       = bus.code[CODE_BITWIDTH-5 -: 8];
   assign w_inst8_ext   = ADDR_BITWIDTH'(w_inst8);
   assign w_unused_code = ^bus.code[CODE_BITWIDTH-13:0];

   // Pointer arithmetic is modulo the tape depth, so MOD wraps in both directions.
   always_comb begin
      w_ptr_next = r_ptr;
      case (bus.flag_op_ptr)
         PTR_NOP: w_ptr_next = r_ptr;
         PTR_MOD: w_ptr_next = w_sign ? (r_ptr - w_inst8_ext) : (r_ptr + w_inst8_ext);
         PTR_SET: w_ptr_next = ADDR_BITWIDTH'(w_inst12);
         PTR_RST: w_ptr_next = '0;
         default: w_ptr_next = r_ptr;
      endcase
   end

   // FSM: state register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_CLEAR;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM: next state; leave CLEAR on the edge that zeroes the last address
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_CLEAR: if (&r_clr_addr) w_state_next = S_READY;
         S_READY: w_state_next = S_READY;
         default: w_state_next = S_CLEAR;
      endcase
   end

   // FSM: outputs; the RAM write port is shared between the clear sweep and user writes
   always_comb begin
      w_busy      = 1'b0;
      w_mem_we    = 1'b0;
      w_mem_addr  = r_ptr;
      w_mem_wdata = bus.data_in;
      case (r_state)
         S_CLEAR: begin
            w_busy      = 1'b1;
            w_mem_we    = 1'b1;
            w_mem_addr  = r_clr_addr;
            w_mem_wdata = '0;
         end
         S_READY: begin
            w_mem_we = bus.data_wr;
         end
         default: begin
            w_busy = 1'b1;
         end
      endcase
   end

   // A write lands in the old cell this edge; if the pointer does not move the RAM read
   // would return the stale value, so the incoming data is forwarded instead.
   assign w_fwd = bus.data_wr && (w_ptr_next == r_ptr);

   always_ff @(posedge i_clk) begin
      if (w_mem_we && !i_rst) begin
         r_mem[w_mem_addr] <= w_mem_wdata;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ptr      <= '0;
         r_data     <= '0;
         r_clr_addr <= '0;
      end else if (r_state == S_CLEAR) begin
         r_ptr      <= '0;
         r_data     <= '0;
         r_clr_addr <= r_clr_addr + 1'b1;
      end else begin
         r_ptr  <= w_ptr_next;
         r_data <= w_fwd ? bus.data_in : r_mem[w_ptr_next];
      end
   end

   assign bus.data = r_data;
   assign bus.ptr  = r_ptr;
   assign bus.busy = w_busy;
endmodule

// File: tb/tb_data_tape.sv
// tb/tb_data_tape.sv - scoreboard bench for data_tape with directed vectors
// Ports: none (top-level bench); drives the DUT through a data_tape_if instance.
module tb_data_tape;
   localparam int         DW     = 8;
   localparam int         CW     = 16;
   localparam int         AW     = 10;
   localparam logic [1:0] OP_NOP = 2'h0;
   localparam logic [1:0] OP_MOD = 2'h1;
   localparam logic [1:0] OP_SET = 2'h2;
   localparam logic [1:0] OP_RST = 2'h3;

   logic clk = 1'b0;
   logic rst = 1'b1;

   data_tape_if #(.DATA_BITWIDTH(DW), .CODE_BITWIDTH(CW), .ADDR_BITWIDTH(AW)) bus ();

   data_tape #(.DATA_BITWIDTH(DW), .CODE_BITWIDTH(CW), .ADDR_BITWIDTH(AW)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            cyc;
      string         name;
      logic [AW-1:0] ptr;
      logic [DW-1:0] data;
      logic          busy;
   } exp_t;

   exp_t sb[$];
   int   cyc   = 0;
   int   n_vec = 0;
   int   n_bad = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: outputs are sampled on the falling edge; every expectation carries the
   // cycle it is due in, so a late or early entry also counts as a miscompare.
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         n_vec++;
         if (e.cyc != cyc || bus.ptr !== e.ptr || bus.data !== e.data || bus.busy !== e.busy) begin
            n_bad++;
            $display("FAIL %s cyc=%0d due=%0d: got ptr=%0d data=%h busy=%b, expected ptr=%0d data=%h busy=%b",
                     e.name, cyc, e.cyc, bus.ptr, bus.data, bus.busy, e.ptr, e.data, e.busy);
         end
      end
   end

   task automatic step(input logic r, input logic [1:0] op, input logic [CW-1:0] c,
                       input logic wr, input logic [DW-1:0] din,
                       input logic [AW-1:0] ep, input logic [DW-1:0] ed, input logic eb,
                       input string nm);
      exp_t e;
      rst             = r;
      bus.flag_op_ptr = op;
      bus.code        = c;
      bus.data_wr     = wr;
      bus.data_in     = din;
      e.cyc  = cyc + 1;
      e.name = nm;
      e.ptr  = ep;
      e.data = ed;
      e.busy = eb;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic op(input logic [1:0] o, input logic [CW-1:0] c, input logic wr,
                     input logic [DW-1:0] din, input logic [AW-1:0] ep,
                     input logic [DW-1:0] ed, input string nm);
      step(1'b0, o, c, wr, din, ep, ed, 1'b0, nm);
   endtask

   // Clear cycles with a write and a MOD +3 pending; both must be ignored.
   task automatic busy_run(input int n, input string nm);
      for (int i = 0; i < n; i++) begin
         step(1'b0, OP_MOD, 16'h0030, 1'b1, 8'hAA, '0, '0, 1'b1, nm);
      end
   endtask

   task automatic reset_pulse(input string nm);
      step(1'b1, OP_NOP, 16'h0000, 1'b0, 8'h00, '0, '0, 1'b1, nm);
   endtask

   initial begin
      bus.flag_op_ptr = OP_NOP;
      bus.code        = '0;
      bus.data_wr     = 1'b0;
      bus.data_in     = '0;
      @(posedge clk);
      #1;

      // Reset and full clear: busy for exactly 1024 sampled cycles
      reset_pulse("reset");
      busy_run(1023, "clear_busy");
      step(1'b0, OP_MOD, 16'h0030, 1'b1, 8'hAA, 10'd0, 8'h00, 1'b0, "clear_done");

      // Cleared cells read zero, and the ignored write/move left cells 0 and 3 untouched
      op(OP_SET, 16'h0050, 1'b0, 8'h00, 10'd5,    8'h00, "set5");
      op(OP_SET, 16'h3FF0, 1'b0, 8'h00, 10'd1023, 8'h00, "set1023");
      op(OP_SET, 16'h12C0, 1'b0, 8'h00, 10'd300,  8'h00, "set300");
      op(OP_RST, 16'h0000, 1'b0, 8'h00, 10'd0,    8'h00, "rst_mem0");
      op(OP_SET, 16'h0030, 1'b0, 8'h00, 10'd3,    8'h00, "set3_mem3");
      op(OP_RST, 16'h0000, 1'b0, 8'h00, 10'd0,    8'h00, "rst_ptr");

      // Write and forward
      op(OP_NOP, 16'h0000, 1'b1, 8'h41, 10'd0, 8'h41, "wr_fwd");
      op(OP_MOD, 16'h0010, 1'b0, 8'h00, 10'd1, 8'h00, "mod_p1");
      op(OP_MOD, 16'h8010, 1'b0, 8'h00, 10'd0, 8'h41, "mod_m1");

      // Write and move in the same cycle
      op(OP_SET, 16'h0020, 1'b0, 8'h00, 10'd2, 8'h00, "set2");
      op(OP_MOD, 16'h0010, 1'b1, 8'h7F, 10'd3, 8'h00, "wr_move");
      op(OP_MOD, 16'h8010, 1'b0, 8'h00, 10'd2, 8'h7F, "move_back");

      // Wrap-around and truncation
      op(OP_RST, 16'h0000, 1'b0, 8'h00, 10'd0,    8'h41, "rst_again");
      op(OP_MOD, 16'h8010, 1'b0, 8'h00, 10'd1023, 8'h00, "wrap_down");
      op(OP_MOD, 16'h0FF0, 1'b0, 8'h00, 10'd254,  8'h00, "wrap_up");
      op(OP_SET, 16'hFFF0, 1'b0, 8'h00, 10'd1023, 8'h00, "set_trunc");

      // Forwarding on NOP, MOD with zero immediate, and SET to the current cell
      op(OP_NOP, 16'h0000, 1'b1, 8'hC3, 10'd1023, 8'hC3, "wr_1023");
      op(OP_MOD, 16'h8000, 1'b0, 8'h00, 10'd1023, 8'hC3, "mod_zero");
      op(OP_NOP, 16'h0000, 1'b1, 8'h5A, 10'd1023, 8'h5A, "overwrite");
      op(OP_SET, 16'h3FF0, 1'b1, 8'h11, 10'd1023, 8'h11, "set_same_fwd");
      op(OP_RST, 16'h0000, 1'b0, 8'h00, 10'd0,    8'h41, "rst_read0");
      op(OP_MOD, 16'h8800, 1'b0, 8'h00, 10'd896,  8'h00, "mod_m128");

      // Reset from READY, then again mid-clear: the sweep restarts at address 0
      reset_pulse("reset_ready");
      busy_run(499, "clear_busy2");
      reset_pulse("reset_mid");
      busy_run(1023, "clear_busy3");
      step(1'b0, OP_MOD, 16'h0030, 1'b1, 8'hAA, 10'd0, 8'h00, 1'b0, "clear_done3");
      op(OP_NOP, 16'h0000, 1'b0, 8'h00, 10'd0,    8'h00, "recl_mem0");
      op(OP_SET, 16'h3FF0, 1'b0, 8'h00, 10'd1023, 8'h00, "recl_mem1023");
      op(OP_SET, 16'h0020, 1'b0, 8'h00, 10'd2,    8'h00, "recl_mem2");

      for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() > 0) begin
         $display("FAIL drain: got %0d pending expectations, required 0", sb.size());
         n_bad += sb.size();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
